// File: rtl/vacuum_session_ctrl_pkg.sv
// State encoding, battery width and output bundle shared by the vacuum session
// controller, the schedule matcher and the motor blocks.
package vacuum_pkg;
    localparam int BATT_W  = 7;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_UNDOCK = 3'd1;
    localparam logic [STATE_W-1:0] ST_CLEAN  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RETURN = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd4;

    typedef struct packed {
        logic drive_en;
        logic brush_en;
        logic seek_dock;
        logic charging;
        logic fault;
        logic session_done;
    } vac_outs_t;

    // States in which the wheels move and the stuck detector is live.
    function automatic logic is_moving(logic [STATE_W-1:0] s);
        return (s == ST_UNDOCK) || (s == ST_CLEAN) || (s == ST_RETURN);
    endfunction
endpackage

// File: rtl/vacuum_session_ctrl_if.sv
// Sensor/command inputs and actuator outputs of the vacuum session controller.
// master = upstream/sensor side, slave = the controller.
interface vacuum_session_if;
    import vacuum_pkg::*;

    logic                tick_1s;
    logic                start_cleaning;
    logic [BATT_W-1:0]   battery_level;
    logic                bin_full;
    logic                obstacle_stuck;
    logic                dock_contact;
    logic                clear_fault;
    logic                drive_en;
    logic                brush_en;
    logic                seek_dock;
    logic                charging;
    logic                fault;
    logic                session_done;
    logic [STATE_W-1:0]  state;

    modport master (
        output tick_1s, start_cleaning, battery_level, bin_full,
               obstacle_stuck, dock_contact, clear_fault,
        input  drive_en, brush_en, seek_dock, charging, fault,
               session_done, state
    );

    modport slave (
        input  tick_1s, start_cleaning, battery_level, bin_full,
               obstacle_stuck, dock_contact, clear_fault,
        output drive_en, brush_en, seek_dock, charging, fault,
               session_done, state
    );
endinterface

// File: rtl/vacuum_session_ctrl_sec_down_counter.sv
// Loadable, tick-enabled down-counter that saturates at zero.
// A load always wins over a tick in the same cycle.
module sec_down_counter #(
    parameter  int MAX = 1,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/vacuum_session_ctrl.sv
// Cleaning-session sequencer: undock, timed clean, return to dock, stuck fault.
// Optional resume after a low-battery return is built when VAC_RESUME_EN is defined.
//
// state  | meaning
// IDLE   | parked, charger follows dock contact, waiting for a start
// UNDOCK | driving off the dock before brushes spin up
// CLEAN  | drive + brush, remaining clean time counting down
// RETURN | seeking the dock
// FAULT  | wheels stalled too long, waiting for user acknowledge
module vacuum_session_ctrl
    import vacuum_pkg::*;
#(
    parameter int CLEAN_SECONDS  = 1800,
    parameter int UNDOCK_SECONDS = 3,
    parameter int MIN_BATTERY    = 30,
    parameter int LOW_BATTERY    = 15,
    parameter int STUCK_SECONDS  = 10
) (
    input logic             clk,
    input logic             rst,
    vacuum_session_if.slave bus
);
    localparam int TMR_MAX = (CLEAN_SECONDS > UNDOCK_SECONDS) ? CLEAN_SECONDS : UNDOCK_SECONDS;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int SW      = $clog2(STUCK_SECONDS + 1);

    localparam logic [TW-1:0]     CLEAN_LD  = TW'(CLEAN_SECONDS);
    localparam logic [TW-1:0]     UNDOCK_LD = TW'(UNDOCK_SECONDS);
    localparam logic [SW-1:0]     STUCK_LD  = SW'(STUCK_SECONDS);
    localparam logic [BATT_W-1:0] MIN_B     = BATT_W'(MIN_BATTERY);
    localparam logic [BATT_W-1:0] LOW_B     = BATT_W'(LOW_BATTERY);

    logic [STATE_W-1:0] state_q, state_nxt;
    vac_outs_t          outs_q;
    logic               start_q, start_rise_q, armed_q;
    logic               tmr_load, stk_load;
    logic [TW-1:0]      tmr_ld_val, tmr_cnt, clean_ld;
    logic [SW-1:0]      stk_cnt;
    logic               batt_ok, batt_low, stuck_trip, resume_go, done_ok, done_nxt;

    assign batt_ok    = bus.battery_level >= MIN_B;
    assign batt_low   = bus.battery_level < LOW_B;
    assign stuck_trip = is_moving(state_q) && (stk_cnt == '0);
    // Stuck seconds must be consecutive and within one state.
    assign stk_load   = !bus.obstacle_stuck || !is_moving(state_q) || (state_nxt != state_q);

`ifdef VAC_RESUME_EN
    logic          resume_q;
    logic [TW-1:0] resume_cnt_q;

    assign resume_go = resume_q && batt_ok;
    assign clean_ld  = resume_q ? resume_cnt_q : CLEAN_LD;
    assign done_ok   = !resume_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resume_q     <= 1'b0;
            resume_cnt_q <= '0;
        end else if (bus.clear_fault) begin
            resume_q     <= 1'b0;
        end else if ((state_q == ST_CLEAN) && (state_nxt == ST_RETURN) && batt_low && (tmr_cnt != '0)) begin
            resume_q     <= 1'b1;
            resume_cnt_q <= tmr_cnt;
        end else if ((state_q == ST_UNDOCK) && (state_nxt == ST_CLEAN)) begin
            resume_q     <= 1'b0;
        end
    end
`else
    assign resume_go = 1'b0;
    assign clean_ld  = CLEAN_LD;
    assign done_ok   = 1'b1;
`endif

    always_comb begin
        state_nxt  = state_q;
        tmr_load   = 1'b0;
        tmr_ld_val = UNDOCK_LD;
        done_nxt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((start_rise_q && batt_ok && !bus.bin_full) || resume_go) begin
                    state_nxt = ST_UNDOCK;
                    tmr_load  = 1'b1;
                end
            end
            ST_UNDOCK: begin
                if (stuck_trip) begin
                    state_nxt = ST_FAULT;
                end else if (tmr_cnt == '0) begin
                    state_nxt  = ST_CLEAN;
                    tmr_load   = 1'b1;
                    tmr_ld_val = clean_ld;
                end
            end
            ST_CLEAN: begin
                if (stuck_trip) begin
                    state_nxt = ST_FAULT;
                end else if (batt_low || bus.bin_full || (tmr_cnt == '0)) begin
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (stuck_trip) begin
                    state_nxt = ST_FAULT;
                end else if (bus.dock_contact) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = done_ok;
                end
            end
            ST_FAULT: begin
                if (bus.clear_fault && !bus.obstacle_stuck) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sec_down_counter #(.MAX(TMR_MAX)) u_sec_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .tick     (bus.tick_1s),
        .count    (tmr_cnt)
    );

    sec_down_counter #(.MAX(STUCK_SECONDS)) u_stuck_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (stk_load),
        .load_val (STUCK_LD),
        .tick     (bus.tick_1s),
        .count    (stk_cnt)
    );

    // armed_q masks a start level that is already high when reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            outs_q       <= '0;
            start_q      <= 1'b0;
            start_rise_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            armed_q             <= 1'b1;
            start_q             <= bus.start_cleaning;
            start_rise_q        <= armed_q && bus.start_cleaning && !start_q;
            state_q             <= state_nxt;
            outs_q.drive_en     <= is_moving(state_nxt);
            outs_q.brush_en     <= (state_nxt == ST_CLEAN);
            outs_q.seek_dock    <= (state_nxt == ST_RETURN);
            outs_q.charging     <= (state_nxt == ST_IDLE) && bus.dock_contact;
            outs_q.fault        <= (state_nxt == ST_FAULT);
            outs_q.session_done <= done_nxt;
        end
    end

    assign bus.drive_en     = outs_q.drive_en;
    assign bus.brush_en     = outs_q.brush_en;
    assign bus.seek_dock    = outs_q.seek_dock;
    assign bus.charging     = outs_q.charging;
    assign bus.fault        = outs_q.fault;
    assign bus.session_done = outs_q.session_done;
    assign bus.state        = state_q;
endmodule
